// File: rtl/glb_pkg.sv
// Shared definitions for the psum global buffer: write modes and FSM states.
package glb_pkg;

  localparam logic W_MODE_OVERWRITE = 1'b0;
  localparam logic W_MODE_ACCUM     = 1'b1;

  typedef enum logic [1:0] {
    GLB_IDLE  = 2'd0,
    GLB_DRAIN = 2'd1,
    GLB_CLEAR = 2'd2
  } glb_state_t;

endpackage

// File: rtl/psum_add_sat.sv
// Combinational signed W+W -> W adder with optional saturation and an
// out-of-range flag.
module psum_add_sat #(
  parameter int unsigned DATA_BITWIDTH = 16,
  parameter bit          SATURATE      = 1'b1
) (
  input  logic [DATA_BITWIDTH-1:0] a,
  input  logic [DATA_BITWIDTH-1:0] b,
  output logic [DATA_BITWIDTH-1:0] sum,
  output logic                     ovf
);

  localparam int unsigned W = DATA_BITWIDTH;

  logic [W:0] ext;

  // Sum at W+1 bits; the two top bits disagree exactly when W bits cannot hold it
  always_comb begin
    ext = {a[W-1], a} + {b[W-1], b};
    ovf = ext[W] ^ ext[W-1];
    sum = ext[W-1:0];
    if (SATURATE && ovf) begin
      sum = ext[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/glb_psum_acc.sv
// Psum global buffer with in-place accumulate, single-word and row reads,
// and a hardware zero sweep of the whole memory.
module glb_psum_acc
  import glb_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH = 16,
  parameter int unsigned ADDR_BITWIDTH = 10,
  parameter int unsigned X_dim         = 3,
  parameter bit          SATURATE      = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            write_en,
  input  logic                            w_mode,
  input  logic [ADDR_BITWIDTH-1:0]        w_addr,
  input  logic [DATA_BITWIDTH-1:0]        w_data,
  input  logic                            read_req,
  input  logic [ADDR_BITWIDTH-1:0]        r_addr,
  output logic [DATA_BITWIDTH-1:0]        r_data,
  output logic                            r_valid,
  input  logic                            read_req_inter,
  input  logic [ADDR_BITWIDTH-1:0]        r_addr_inter,
  output logic [DATA_BITWIDTH*X_dim-1:0]  r_data_inter,
  output logic                            read_en_inter,
  input  logic                            clear_req,
  output logic                            busy,
  output logic                            clear_done,
  output logic                            sat_flag
);

  localparam int unsigned W     = DATA_BITWIDTH;
  localparam int unsigned A     = ADDR_BITWIDTH;
  localparam int unsigned DEPTH = 1 << A;
  localparam logic [A-1:0] LAST_ADDR = {A{1'b1}};

  logic [W-1:0] mem [DEPTH];

  glb_state_t   state;
  logic [A-1:0] clr_addr;

  logic         s1_valid;
  logic [A-1:0] s1_addr;
  logic [W-1:0] s1_addend;
  logic [W-1:0] s1_old;

  logic         idle_c;
  logic         ow_c;
  logic         acc_c;
  logic         commit_c;
  logic [W-1:0] acc_sum_c;
  logic         acc_ovf_c;
  logic [W-1:0] old_fwd_c;

  psum_add_sat #(
    .DATA_BITWIDTH(W),
    .SATURATE     (SATURATE)
  ) u_add (
    .a  (s1_old),
    .b  (s1_addend),
    .sum(acc_sum_c),
    .ovf(acc_ovf_c)
  );

  // Request qualification; the pending accumulate loses to a same-address overwrite
  always_comb begin
    idle_c    = (state == GLB_IDLE);
    ow_c      = idle_c && write_en && (w_mode == W_MODE_OVERWRITE);
    acc_c     = idle_c && write_en && (w_mode == W_MODE_ACCUM);
    commit_c  = s1_valid && !(ow_c && (w_addr == s1_addr));
    old_fwd_c = (s1_valid && (s1_addr == w_addr)) ? acc_sum_c : mem[w_addr];
  end

  always_ff @(posedge clk) begin
    if (state == GLB_CLEAR) begin
      mem[clr_addr] <= '0;
    end
    if (commit_c) begin
      mem[s1_addr] <= acc_sum_c;
    end
    if (ow_c) begin
      mem[w_addr] <= w_data;
    end
  end

  // Accumulate S1 capture plus the clear-sweep FSM; S2 is the commit above
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= GLB_IDLE;
      clr_addr   <= '0;
      s1_valid   <= 1'b0;
      s1_addr    <= '0;
      s1_addend  <= '0;
      s1_old     <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      s1_valid   <= acc_c;
      if (acc_c) begin
        s1_addr   <= w_addr;
        s1_addend <= w_data;
        s1_old    <= old_fwd_c;
      end
      if (s1_valid && acc_ovf_c) begin
        sat_flag <= 1'b1;
      end
      case (state)
        GLB_IDLE: begin
          if (clear_req) begin
            busy     <= 1'b1;
            clr_addr <= '0;
            state    <= acc_c ? GLB_DRAIN : GLB_CLEAR;
          end
        end
        GLB_DRAIN: begin
          state <= GLB_CLEAR;
        end
        GLB_CLEAR: begin
          clr_addr <= clr_addr + A'(1);
          if (clr_addr == LAST_ADDR) begin
            state      <= GLB_IDLE;
            busy       <= 1'b0;
            clear_done <= 1'b1;
            sat_flag   <= 1'b0;
          end
        end
        default: begin
          state <= GLB_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Read ports: one-cycle latency, row lanes wrap modulo depth
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_data_inter  <= '0;
      read_en_inter <= 1'b0;
    end else begin
      r_valid <= idle_c && read_req;
      if (idle_c && read_req) begin
        r_data <= mem[r_addr];
      end
      read_en_inter <= idle_c && read_req_inter;
      for (int k = 0; k < int'(X_dim); k++) begin
        r_data_inter[k*W +: W] <= (idle_c && read_req_inter)
                                  ? mem[A'(r_addr_inter + A'(k))] : '0;
      end
    end
  end

endmodule

// File: tb/tb_glb_psum_acc.sv
// Scoreboard bench for glb_psum_acc: a behavioural memory model predicts
// every read, and a negedge monitor compares DUT read data against it.
module tb_glb_psum_acc;
  import glb_pkg::*;

  localparam int unsigned W     = 16;
  localparam int unsigned A     = 10;
  localparam int unsigned X     = 3;
  localparam int          DEPTH = 1024;

  logic           clk = 1'b0;
  logic           reset;
  logic           write_en;
  logic           w_mode;
  logic [A-1:0]   w_addr;
  logic [W-1:0]   w_data;
  logic           read_req;
  logic [A-1:0]   r_addr;
  logic [W-1:0]   r_data;
  logic           r_valid;
  logic           read_req_inter;
  logic [A-1:0]   r_addr_inter;
  logic [W*X-1:0] r_data_inter;
  logic           read_en_inter;
  logic           clear_req;
  logic           busy;
  logic           clear_done;
  logic           sat_flag;

  glb_psum_acc #(
    .DATA_BITWIDTH(W),
    .ADDR_BITWIDTH(A),
    .X_dim        (X),
    .SATURATE     (1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .write_en      (write_en),
    .w_mode        (w_mode),
    .w_addr        (w_addr),
    .w_data        (w_data),
    .read_req      (read_req),
    .r_addr        (r_addr),
    .r_data        (r_data),
    .r_valid       (r_valid),
    .read_req_inter(read_req_inter),
    .r_addr_inter  (r_addr_inter),
    .r_data_inter  (r_data_inter),
    .read_en_inter (read_en_inter),
    .clear_req     (clear_req),
    .busy          (busy),
    .clear_done    (clear_done),
    .sat_flag      (sat_flag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [W-1:0] ref_mem [DEPTH];
  logic                exp_sat;
  logic [W-1:0]        rd_q  [$];
  logic [W*X-1:0]      row_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard pop side
  always @(negedge clk) begin
    if (r_valid) begin
      if (rd_q.size() == 0) check("rd_spurious", 64'(r_valid), 64'd0);
      else check("r_data", 64'(r_data), 64'(rd_q.pop_front()));
    end
    if (read_en_inter) begin
      if (row_q.size() == 0) check("row_spurious", 64'(read_en_inter), 64'd0);
      else check("r_data_inter", 64'(r_data_inter), 64'(row_q.pop_front()));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic mode, input int addr, input int data);
    int                  s;
    logic signed [W-1:0] d;
    d        = W'(data);
    write_en = 1'b1;
    w_mode   = mode;
    w_addr   = A'(addr);
    w_data   = d;
    if (mode == W_MODE_OVERWRITE) begin
      ref_mem[addr] = d;
    end else begin
      s = int'(ref_mem[addr]) + int'(d);
      if (s > 32767) begin
        s = 32767;
        exp_sat = 1'b1;
      end else if (s < -32768) begin
        s = -32768;
        exp_sat = 1'b1;
      end
      ref_mem[addr] = W'(s);
    end
    @(posedge clk);
    #1;
    write_en = 1'b0;
  endtask

  task automatic do_read(input int addr);
    read_req = 1'b1;
    r_addr   = A'(addr);
    rd_q.push_back(ref_mem[addr]);
    @(posedge clk);
    #1;
    read_req = 1'b0;
  endtask

  task automatic do_row(input int base);
    logic [W*X-1:0] e;
    for (int k = 0; k < int'(X); k++) e[k*W +: W] = ref_mem[(base + k) % DEPTH];
    row_q.push_back(e);
    read_req_inter = 1'b1;
    r_addr_inter   = A'(base);
    @(posedge clk);
    #1;
    read_req_inter = 1'b0;
  endtask

  // Waits for the sweep to finish (or resets at cycle abort_at), poking ignored requests mid-sweep
  task automatic wait_clear(input int exp_cycles, input int abort_at);
    int c;
    bit done;
    c    = 0;
    done = 1'b0;
    while (!done && c < 3000) begin
      @(negedge clk);
      c++;
      if (c == 1) check("busy_start", 64'(busy), 64'd1);
      if (c == 10) begin
        read_req = 1'b1;  r_addr = A'(5);
        read_req_inter = 1'b1; r_addr_inter = A'(0);
        write_en = 1'b1; w_mode = W_MODE_OVERWRITE; w_addr = A'(3); w_data = 16'h0055;
        clear_req = 1'b1;
      end
      if (c == 11) begin
        check("rv_busy", 64'(r_valid), 64'd0);
        check("rie_busy", 64'(read_en_inter), 64'd0);
        check("busy_mid", 64'(busy), 64'd1);
        read_req = 1'b0; read_req_inter = 1'b0; write_en = 1'b0; clear_req = 1'b0;
      end
      if (abort_at != 0 && c == abort_at) begin
        reset = 1'b0;
        done  = 1'b1;
      end else if (clear_done) begin
        done = 1'b1;
      end
    end
    if (abort_at == 0) begin
      check("clear_cycles", 64'(c), 64'(exp_cycles));
      check("sat_after_clear", 64'(sat_flag), 64'd0);
      @(negedge clk);
      check("clear_done_pulse", 64'(clear_done), 64'd0);
      check("busy_end", 64'(busy), 64'd0);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      exp_sat = 1'b0;
    end else begin
      check("abort_at", 64'(c), 64'(abort_at));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; write_en = 1'b0; w_mode = 1'b0; w_addr = '0; w_data = '0;
    read_req = 1'b0; r_addr = '0; read_req_inter = 1'b0; r_addr_inter = '0;
    clear_req = 1'b0; exp_sat = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    repeat (3) @(negedge clk);
    check("rst_r_data", 64'(r_data), 64'd0);
    check("rst_r_valid", 64'(r_valid), 64'd0);
    check("rst_row", 64'(r_data_inter), 64'd0);
    check("rst_rie", 64'(read_en_inter), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(clear_done), 64'd0);
    check("rst_sat", 64'(sat_flag), 64'd0);
    reset = 1'b1;
    idle(1);

    // Overwrite then read, r_data holds afterwards
    do_write(W_MODE_OVERWRITE, 5, 100);
    do_read(5);
    idle(2);
    check("r_data_hold", 64'(r_data), 64'd100);
    check("r_valid_idle", 64'(r_valid), 64'd0);

    // Back-to-back accumulate chain
    do_write(W_MODE_OVERWRITE, 7, 10);
    do_write(W_MODE_ACCUM, 7, 3);
    do_write(W_MODE_ACCUM, 7, 4);
    do_write(W_MODE_ACCUM, 7, 5);
    idle(2);
    do_read(7);
    idle(1);
    check("acc_chain_model", 64'(ref_mem[7]), 64'd22);
    check("sat_clean", 64'(sat_flag), 64'd0);

    // Overwrite-then-accumulate and accumulate/overwrite collision
    do_write(W_MODE_OVERWRITE, 11, 50);
    do_write(W_MODE_ACCUM, 11, 7);
    do_write(W_MODE_ACCUM, 9, 1);
    do_write(W_MODE_OVERWRITE, 9, 1234);
    idle(2);
    do_read(11);
    do_read(9);
    idle(1);

    // Row read wrapping past the top of memory
    do_write(W_MODE_OVERWRITE, 1023, 9);
    do_write(W_MODE_OVERWRITE, 0, 8);
    do_write(W_MODE_OVERWRITE, 1, 7);
    do_row(1023);
    idle(2);
    check("row_idle_zero", 64'(r_data_inter), 64'd0);
    check("row_idle_en", 64'(read_en_inter), 64'd0);

    // Saturation both ways, then the clear sweep drops sat_flag
    do_write(W_MODE_OVERWRITE, 2, 32760);
    do_write(W_MODE_ACCUM, 2, 100);
    do_write(W_MODE_OVERWRITE, 4, -32760);
    do_write(W_MODE_ACCUM, 4, -100);
    idle(2);
    do_read(2);
    do_read(4);
    idle(1);
    check("sat_set", 64'(sat_flag), 64'(exp_sat));
    clear_req = 1'b1;
    idle(1);
    clear_req = 1'b0;
    wait_clear(1025, 0);

    // Random overwrite/accumulate mix on a small window
    for (int i = 0; i < 16; i++) do_write(W_MODE_OVERWRITE, i, int'($urandom_range(0, 65535)));
    for (int i = 0; i < 60; i++)
      do_write(logic'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 4000)) - 2000);
    idle(2);
    for (int i = 0; i < 16; i++) do_read(i);
    do_row(14);
    idle(2);
    check("sat_rand", 64'(sat_flag), 64'(exp_sat));

    // Clear with accumulates in flight, then every address reads zero
    do_write(W_MODE_ACCUM, 20, 5);
    write_en = 1'b1; w_mode = W_MODE_ACCUM; w_addr = A'(20); w_data = 16'd6;
    clear_req = 1'b1;
    idle(1);
    write_en = 1'b0; clear_req = 1'b0;
    wait_clear(1026, 0);
    for (int i = 0; i < DEPTH; i++) do_read(i);
    idle(2);

    // Reset in the middle of a sweep
    do_write(W_MODE_OVERWRITE, 299, 11);
    do_write(W_MODE_OVERWRITE, 301, 33);
    do_write(W_MODE_OVERWRITE, 500, -5);
    do_write(W_MODE_OVERWRITE, 300, 32767);
    do_write(W_MODE_ACCUM, 300, 1);
    idle(2);
    do_read(500);
    idle(1);
    check("pre_rst_sat", 64'(sat_flag), 64'd1);
    clear_req = 1'b1;
    idle(1);
    clear_req = 1'b0;
    wait_clear(0, 301);
    #1;
    check("mid_rst_r_data", 64'(r_data), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_sat", 64'(sat_flag), 64'd0);
    check("mid_rst_done", 64'(clear_done), 64'd0);
    check("mid_rst_row", 64'(r_data_inter), 64'd0);
    for (int i = 0; i < 300; i++) ref_mem[i] = '0;
    exp_sat = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    do_read(299);
    do_read(300);
    do_read(301);
    do_read(500);
    do_row(298);
    idle(3);
    check("rd_q_empty", 64'(rd_q.size()), 64'd0);
    check("row_q_empty", 64'(row_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
